// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module  : dmem_arb_pkg
// Brief   : Shared types, constants and address check for the dmem arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int WORD_BYTES = 8;
    localparam int DMEM_DEPTH = 32;

    // True when the byte address is doubleword aligned and inside the memory.
    function automatic logic addr_ok(input logic [63:0] addr, input int unsigned depth);
        return (addr[2:0] == 3'b000) &&
               (addr < 64'(depth) * 64'(WORD_BYTES));
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker; lowest index at/after ptr wins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import dmem_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            valid,
    output logic [PW-1:0]   idx,
    output logic [NREQ-1:0] onehot
);

    always_comb begin
        int j;
        j      = 0;
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!valid && req[j]) begin
                valid     = 1'b1;
                idx       = PW'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Round-robin sharing of a single-ported data memory, one access at a time.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int DEPTH = DMEM_DEPTH,
    parameter int AW    = 64,
    parameter int DW    = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    resp_valid,
    output logic             resp_err,
    output logic [DW-1:0]    resp_rdata,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    output logic             mem_we,
    output logic             mem_re,
    input  logic [DW-1:0]    mem_rdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_q, state_d;
    logic [PW-1:0]   id_q, id_d;
    logic [NREQ-1:0] id_oh_q, id_oh_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

    logic            arb_en;
    logic [PW-1:0]   ptr_next;
    logic [PW-1:0]   pick_ptr;
    logic [NREQ-1:0] pick_req;
    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_oh;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_ok;

    assign arb_en   = (state_q == IDLE) || (state_q == RESP);
    assign ptr_next = (id_q == PW'(NREQ - 1)) ? '0 : id_q + PW'(1);
    // The finishing requester may still show req in RESP; it gets no say there.
    assign pick_req = (state_q == RESP) ? (req & ~id_oh_q) : req;
    assign pick_ptr = (state_q == RESP) ? ptr_next : rr_ptr_q;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    assign sel_addr  = addr[int'(pick_idx)*AW +: AW];
    assign sel_wdata = wdata[int'(pick_idx)*DW +: DW];
    assign sel_ok    = addr_ok(64'(sel_addr), DEPTH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            id_q        <= '0;
            id_oh_q     <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            rr_ptr_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            id_oh_q     <= id_oh_d;
            we_q        <= we_d;
            err_q       <= err_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        id_oh_d     = id_oh_q;
        we_d        = we_q;
        err_d       = err_q;
        rr_ptr_d    = rr_ptr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (state_q == RESP) begin
            rr_ptr_d = ptr_next;
        end

        case (state_q)
            IDLE, RESP: begin
                if (pick_valid) begin
                    state_d = ACCESS;
                    id_d    = pick_idx;
                    id_oh_d = pick_oh;
                    we_d    = we[pick_idx];
                    err_d   = !sel_ok;
                    // Bad addresses leave the memory-side registers untouched.
                    if (sel_ok) begin
                        mem_addr_d = sel_addr;
                        if (we[pick_idx]) begin
                            mem_wdata_d = sel_wdata;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt        = '0;
        resp_valid = '0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        if (state_q == ACCESS) begin
            gnt    = id_oh_q;
            mem_we = !err_q && we_q;
            mem_re = !err_q && !we_q;
        end
        if (state_q == RESP) begin
            resp_valid = id_oh_q;
            resp_err   = err_q;
            if (!err_q && !we_q) begin
                resp_rdata = mem_rdata;
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Directed self-checking bench for dmem_arbiter with a clocked memory model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 64;
    localparam int DW   = 64;

    logic             clk;
    logic             reset_n;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    resp_valid;
    logic             resp_err;
    logic [DW-1:0]    resp_rdata;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic             mem_we;
    logic             mem_re;
    logic [DW-1:0]    mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mem [32] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                              16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31};

    dmem_arbiter #(
        .NREQ  (NREQ),
        .DEPTH (32),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .gnt        (gnt),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: write on MemWrite, readData registered on MemRead, zero otherwise.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:3]] <= mem_wdata;
        mem_rdata <= mem_re ? mem[mem_addr[7:3]] : 64'd0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input logic w, input logic [63:0] a, input logic [63:0] d);
        req[r]            = 1'b1;
        we[r]             = w;
        addr[r*AW +: AW]  = a;
        wdata[r*DW +: DW] = d;
    endtask

    // Single isolated transaction with exact-latency checks on every cycle.
    task automatic txn(input string tag, input int r, input logic w, input logic [63:0] a,
                       input logic [63:0] d, input logic [63:0] exp_rd, input logic exp_err);
        logic [1:0] oh;
        oh = 2'b01 << r;
        drive(r, w, a, d);
        tick();
        chk({tag, "_gnt"}, 64'(gnt), 64'(oh));
        chk({tag, "_rv_a"}, 64'(resp_valid), 64'd0);
        chk({tag, "_re_a"}, 64'(mem_re), 64'(!exp_err && !w));
        chk({tag, "_we_a"}, 64'(mem_we), 64'(!exp_err && w));
        if (!exp_err) chk({tag, "_maddr"}, mem_addr, a);
        if (!exp_err && w) chk({tag, "_mwdata"}, mem_wdata, d);
        req[r] = 1'b0;
        tick();
        chk({tag, "_rv"}, 64'(resp_valid), 64'(oh));
        chk({tag, "_err"}, 64'(resp_err), 64'(exp_err));
        chk({tag, "_rdata"}, resp_rdata, exp_rd);
        chk({tag, "_gnt_r"}, 64'(gnt), 64'd0);
        chk({tag, "_strb_r"}, 64'({mem_re, mem_we}), 64'd0);
        tick();
        chk({tag, "_idle"}, 64'({gnt, resp_valid, mem_re, mem_we}), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        req     = '0;
        we      = '0;
        addr    = '0;
        wdata   = '0;
        #1;
        chk("rst_gnt",   64'(gnt), 64'd0);
        chk("rst_rv",    64'(resp_valid), 64'd0);
        chk("rst_err",   64'(resp_err), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_strb",  64'({mem_re, mem_we}), 64'd0);
        chk("rst_maddr", mem_addr, 64'd0);
        chk("rst_mwd",   mem_wdata, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        tick();

        // Basic read, then write/read-back
        txn("rd28", 0, 1'b0, 64'h28, 64'd0, 64'd5, 1'b0);
        txn("wr10", 1, 1'b1, 64'h10, 64'hDEADBEEF, 64'd0, 1'b0);
        txn("rd10", 1, 1'b0, 64'h10, 64'd0, 64'hDEADBEEF, 1'b0);

        // Error responses and range boundaries
        txn("mis0c",  0, 1'b0, 64'h0C,  64'd0, 64'd0, 1'b1);
        txn("oor100", 1, 1'b0, 64'h100, 64'd0, 64'd0, 1'b1);
        txn("wrmis",  0, 1'b1, 64'h12,  64'h55, 64'd0, 1'b1);
        txn("rd10b",  1, 1'b0, 64'h10,  64'd0, 64'hDEADBEEF, 1'b0);
        txn("rdf8",   0, 1'b0, 64'hF8,  64'd0, 64'd31, 1'b0);
        txn("rd00",   1, 1'b0, 64'h00,  64'd0, 64'd0, 1'b0);

        // Both requesters held: alternating grants, one transaction per 2 cycles
        drive(0, 1'b0, 64'h08, 64'd0);
        drive(1, 1'b0, 64'h20, 64'd0);
        for (int i = 0; i < 8; i++) begin
            int r;
            r = (i / 2) % 2;
            tick();
            if (i % 2 == 0) begin
                chk("alt_gnt", 64'(gnt), 64'(2'b01 << r));
                chk("alt_maddr", mem_addr, (r == 0) ? 64'h08 : 64'h20);
                chk("alt_re", 64'(mem_re), 64'd1);
            end else begin
                chk("alt_rv", 64'(resp_valid), 64'(2'b01 << r));
                chk("alt_rdata", resp_rdata, (r == 0) ? 64'd1 : 64'd4);
                chk("alt_gnt_r", 64'(gnt), 64'd0);
            end
        end
        req = '0;
        tick();
        chk("alt_idle", 64'({gnt, resp_valid}), 64'd0);

        // Back-to-back write then read from different requesters
        drive(0, 1'b1, 64'h30, 64'hCAFE);
        drive(1, 1'b0, 64'h30, 64'd0);
        tick();
        chk("b2b_gnt0", 64'(gnt), 64'b01);
        chk("b2b_we",   64'(mem_we), 64'd1);
        chk("b2b_wd",   mem_wdata, 64'hCAFE);
        req[0] = 1'b0;
        tick();
        chk("b2b_rv0",  64'(resp_valid), 64'b01);
        chk("b2b_err0", 64'(resp_err), 64'd0);
        tick();
        chk("b2b_gnt1", 64'(gnt), 64'b10);
        chk("b2b_re",   64'(mem_re), 64'd1);
        req[1] = 1'b0;
        tick();
        chk("b2b_rv1",  64'(resp_valid), 64'b10);
        chk("b2b_rd",   resp_rdata, 64'hCAFE);
        tick();

        // Asynchronous reset in the middle of a write
        drive(0, 1'b1, 64'h18, 64'hBAD);
        tick();
        chk("ar_gnt", 64'(gnt), 64'b01);
        chk("ar_we",  64'(mem_we), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("ar_outs", 64'({gnt, resp_valid, resp_err, mem_re, mem_we}), 64'd0);
        chk("ar_maddr", mem_addr, 64'd0);
        chk("ar_mwd",   mem_wdata, 64'd0);
        req = '0;
        we  = '0;
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        tick();
        chk("ar_norv", 64'({gnt, resp_valid}), 64'd0);
        txn("ar_rd18", 0, 1'b0, 64'h18, 64'd0, 64'd3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
